// File: rtl/iram_init_sequencer.sv
// iram_init_sequencer: boot-time loader that streams 9-bit words into the instruction RAM init port.
// Optional checksum stage is compiled in with `define IRAM_INIT_CHECKSUM_EN.
// Ports:
//   CLK, RESET        clock, synchronous active-high reset
//   START             single-cycle pulse that begins a load (ignored while BUSY)
//   S_VALID/S_DATA    source word stream; S_READY high when a word is accepted
//   INITADDR/INITDATA RAM init address/data, held after the strobe
//   INITDATVAL        one-cycle RAM write strobe
//   INITDONE          load complete, RAM handed to the core
//   BUSY              load in progress (LOAD, WRITE or CHECK)
//   ERROR             sticky load failure (timeout or checksum)
//   WCOUNT            words written in the current load
module iram_init_sequencer #(
    parameter int INITWIDTH = 7,
    parameter int NWORDS    = 128,
    parameter int TIMEOUT   = 4096,
    parameter int TOWIDTH   = 13
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 START,
    input  logic                 S_VALID,
    input  logic [8:0]           S_DATA,
    output logic                 S_READY,
    output logic [INITWIDTH-1:0] INITADDR,
    output logic [8:0]           INITDATA,
    output logic                 INITDATVAL,
    output logic                 INITDONE,
    output logic                 BUSY,
    output logic                 ERROR,
    output logic [INITWIDTH:0]   WCOUNT
);
    localparam logic [INITWIDTH:0] LP_NWORDS = (INITWIDTH+1)'(NWORDS);
    localparam logic [TOWIDTH-1:0] LP_TOLAST = TOWIDTH'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WRITE,
`ifdef IRAM_INIT_CHECKSUM_EN
        CHECK,
`endif
        DONE,
        ERR
    } state_t;

    state_t               r_state, w_next;
    logic [INITWIDTH:0]   r_wcount;
    logic [INITWIDTH-1:0] r_addr;
    logic [8:0]           r_data;
    logic                 r_datval, r_done, r_error;
    logic [TOWIDTH-1:0]   r_to;
    logic                 w_hs, w_to, w_last, w_start, w_wait;
`ifdef IRAM_INIT_CHECKSUM_EN
    logic [8:0]           r_sum;
    assign w_wait = r_state == LOAD || r_state == CHECK;
`else
    assign w_wait = r_state == LOAD;
`endif

    assign S_READY    = w_wait;
    assign BUSY       = w_wait || r_state == WRITE;
    assign w_hs       = S_VALID && S_READY;
    // Counter is compared one short of TIMEOUT so ERR is entered on the TIMEOUT-th idle cycle
    assign w_to       = (TIMEOUT != 0) && (r_to == LP_TOLAST);
    assign w_last     = (r_wcount + 1'b1) == LP_NWORDS;
    assign w_start    = START && (r_state == IDLE || r_state == DONE || r_state == ERR);
    assign INITADDR   = r_addr;
    assign INITDATA   = r_data;
    assign INITDATVAL = r_datval;
    assign INITDONE   = r_done;
    assign ERROR      = r_error;
    assign WCOUNT     = r_wcount;

    always_ff @(posedge CLK) begin
        if (RESET) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = START ? LOAD : IDLE;
            LOAD:    w_next = w_hs ? WRITE : (w_to ? ERR : LOAD);
`ifdef IRAM_INIT_CHECKSUM_EN
            WRITE:   w_next = w_last ? CHECK : LOAD;
            CHECK:   w_next = w_hs ? ((S_DATA == r_sum) ? DONE : ERR) : (w_to ? ERR : CHECK);
`else
            WRITE:   w_next = w_last ? DONE : LOAD;
`endif
            DONE:    w_next = START ? LOAD : DONE;
            ERR:     w_next = START ? LOAD : ERR;
            default: w_next = IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they line up with the state they describe
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_wcount <= '0;
            r_addr   <= '0;
            r_data   <= '0;
            r_datval <= 1'b0;
            r_done   <= 1'b0;
            r_error  <= 1'b0;
            r_to     <= '0;
`ifdef IRAM_INIT_CHECKSUM_EN
            r_sum    <= '0;
`endif
        end else begin
            r_datval <= w_next == WRITE;
            r_done   <= w_next == DONE;
            r_error  <= w_next == ERR;
            if (w_start) begin
                r_wcount <= '0;
                r_to     <= '0;
`ifdef IRAM_INIT_CHECKSUM_EN
                r_sum    <= '0;
`endif
            end
            if (r_state == LOAD && w_hs) begin
                r_data <= S_DATA;
                r_addr <= r_wcount[INITWIDTH-1:0];
                r_to   <= '0;
            end else if (w_wait) begin
                r_to <= r_to + 1'b1;
            end
            if (r_state == WRITE) begin
                r_wcount <= r_wcount + 1'b1;
`ifdef IRAM_INIT_CHECKSUM_EN
                r_sum    <= r_sum + r_data;
`endif
            end
        end
    end
endmodule
